dac_spi_serializer: RTL and testbench

- Downstream consumer of the LUT waveform generator: accepts one sample per handshake and serializes it as a fixed-width SPI frame to an external DAC (AD5683-class, 24-bit frame).
- Converts signed two's-complement LUT output to offset binary on request.
- Forwards the waveform end-of-period flag as a frame-aligned sync pulse for scope triggering and system test.

---
 rtl/dac_spi_serializer_pkg.sv | 29 ++
 rtl/dac_spi_serializer_if.sv | 16 +
 rtl/dac_spi_serializer_sclk.sv | 40 ++++
 rtl/dac_spi_serializer.sv | 142 ++++++++++++++
 tb/tb_dac_spi_serializer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_serializer_pkg.sv
// dac_spi_pkg: shared types and helpers for the DAC SPI serializer.
//   state_t          - serializer FSM states
//   PAD_BITS         - zero-pad width of the default frame layout (24 = 8 + 16 + 0)
//   to_offset_bin()  - two's complement -> offset binary (MSB flip) for any width
//                      up to CONV_MAX_W
package dac_spi_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int DEF_BIT_WIDTH   = 16;
    localparam int DEF_FRAME_WIDTH = 24;
    localparam int DEF_CMD_BITS    = 8;
    localparam int PAD_BITS        = DEF_FRAME_WIDTH - DEF_CMD_BITS - DEF_BIT_WIDTH;

    localparam int CONV_MAX_W = 64;

    // Flipping the sign bit maps -2^(w-1)..2^(w-1)-1 onto 0..2^w-1.
    function automatic logic [CONV_MAX_W-1:0] to_offset_bin(
        input logic [CONV_MAX_W-1:0] d,
        input int                    width,
        input bit                    signed_in
    );
        logic [CONV_MAX_W-1:0] r;
        r = d;
        if (signed_in) r[width-1] = ~r[width-1];
        return r;
    endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample stream into the serializer (normally fed by the LUT waveform generator).
//   data_in     - sample
//   data_valid  - sample strobe
//   lut_end_in  - end-of-waveform flag, qualified by data_valid
//   data_ready  - sink can take a sample this cycle
interface dac_spi_serializer_if #(
    parameter int BIT_WIDTH = 16
);
    logic [BIT_WIDTH-1:0] data_in;
    logic                 data_valid;
    logic                 lut_end_in;
    logic                 data_ready;

    modport master (output data_in, data_valid, lut_end_in, input  data_ready);
    modport slave  (input  data_in, data_valid, lut_end_in, output data_ready);
endinterface

// File: rtl/dac_spi_serializer_sclk.sv
// spi_sclk_divider: SCLK generator for SPI stages.
//   clk, rst  - system clock, synchronous active-high reset
//   run       - high while a frame is shifting; low holds counter and SCLK at 0
//   sclk      - SPI clock, starts low, toggles every CLK_DIV cycles of run
//   rise/fall - one-cycle enables, high in the cycle whose clock edge moves sclk
module spi_sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_div
        $fatal(1, "spi_sclk_divider: CLK_DIV must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == CW'(CLK_DIV - 1));
    assign rise = run && tick && !sclk;
    assign fall = run && tick &&  sclk;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: takes one sample per handshake and sends it as a
// {CMD_WORD, sample, zero pad} SPI frame (mode 1, MSB first) to a DAC.
//   clk_sys, rst   - system clock, synchronous active-high reset
//   en             - block enable; low aborts any frame and holds idle
//   smp            - sample stream (slave side)
//   sclk/mosi/cs_n - SPI pins
//   busy           - frame or inter-frame gap in progress
//   frame_done     - pulse in the first cycle after CS_N rises on a full frame
//   sync_out       - frame_done for a frame that carried lut_end_in
//   overrun        - sticky: a sample arrived while not ready (sample dropped)
module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int                  BIT_WIDTH   = 16,
    parameter int                  FRAME_WIDTH = 24,
    parameter int                  CMD_BITS    = 8,
    parameter logic [CMD_BITS-1:0] CMD_WORD    = 8'h30,
    parameter int                  CLK_DIV     = 4,
    parameter int                  CS_GAP      = 2,
    parameter int                  SIGNED_IN   = 1
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  en,
    dac_spi_serializer_if.slave   smp,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sync_out,
    output logic                  overrun
);
    localparam int PAD          = FRAME_WIDTH - CMD_BITS - BIT_WIDTH;
    localparam int SHIFT_CYCLES = 2 * CLK_DIV * FRAME_WIDTH;
    localparam int SCW          = $clog2(SHIFT_CYCLES + 1);
    localparam int GCW          = $clog2(CS_GAP + 1);

    if (FRAME_WIDTH < CMD_BITS + BIT_WIDTH) begin : g_bad_frame
        $fatal(1, "dac_spi_serializer: FRAME_WIDTH < CMD_BITS + BIT_WIDTH");
    end
    if (CS_GAP < 1) begin : g_bad_gap
        $fatal(1, "dac_spi_serializer: CS_GAP must be >= 1");
    end
    if (BIT_WIDTH > CONV_MAX_W) begin : g_bad_width
        $fatal(1, "dac_spi_serializer: BIT_WIDTH too large");
    end

    state_t                 state;
    logic [FRAME_WIDTH-1:0] shreg;
    logic [SCW-1:0]         shift_cnt;
    logic [GCW-1:0]         gap_cnt;
    logic                   end_lat;
    logic                   ready;
    logic [BIT_WIDTH-1:0]   conv;
    logic [FRAME_WIDTH-1:0] frame_word;
    logic                   sclk_rise, sclk_fall;

    assign conv       = BIT_WIDTH'(to_offset_bin(CONV_MAX_W'(smp.data_in), BIT_WIDTH, SIGNED_IN != 0));
    // Shifting left leaves PAD zeros at the bottom; also works when PAD is 0.
    assign frame_word = FRAME_WIDTH'({CMD_WORD, conv}) << PAD;

    assign smp.data_ready = ready;
    assign busy           = (state != IDLE);

    // en is folded in so an abort drops SCLK on the same edge CS_N rises.
    spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk_sys),
        .rst  (rst),
        .run  (en && state == SHIFT),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= IDLE;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
            sync_out   <= 1'b0;
            overrun    <= 1'b0;
            shreg      <= '0;
            shift_cnt  <= '0;
            gap_cnt    <= '0;
            end_lat    <= 1'b0;
        end else begin
            if (en && smp.data_valid && !ready) overrun <= 1'b1;

            if (!en) begin
                state      <= IDLE;
                cs_n       <= 1'b1;
                mosi       <= 1'b0;
                ready      <= 1'b0;
                frame_done <= 1'b0;
                sync_out   <= 1'b0;
            end else begin
                frame_done <= 1'b0;
                sync_out   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (smp.data_valid && ready) begin
                            shreg     <= frame_word;
                            end_lat   <= smp.lut_end_in;
                            shift_cnt <= '0;
                            cs_n      <= 1'b0;
                            ready     <= 1'b0;
                            state     <= SHIFT;
                        end else begin
                            ready <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        shift_cnt <= shift_cnt + 1'b1;
                        // Launch on SCLK rise, advance on fall: MOSI holds a
                        // full SCLK period around the DAC's falling-edge sample.
                        if (sclk_rise) mosi  <= shreg[FRAME_WIDTH-1];
                        if (sclk_fall) shreg <= shreg << 1;
                        if (shift_cnt == SCW'(SHIFT_CYCLES - 1)) begin
                            state      <= GAP;
                            cs_n       <= 1'b1;
                            mosi       <= 1'b0;
                            frame_done <= 1'b1;
                            sync_out   <= end_lat;
                            gap_cnt    <= '0;
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_cnt == GCW'(CS_GAP - 1)) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer (CLK_DIV=2). A cycle-level timeline model
// predicts handshake/CS_N/BUSY/OVERRUN per cycle; accepted samples push the
// expected frame into a queue that an independent SPI monitor pops on CS_N rise.
module tb_dac_spi_serializer;
    localparam int CLK_DIV = 2;
    localparam int FW      = 24;
    localparam int CS_GAP  = 2;
    localparam int SHIFT_N = 2 * CLK_DIV * FW;          // 96
    localparam int BUSY_N  = SHIFT_N + CS_GAP;          // 98

    typedef struct {
        logic [23:0] word;
        bit          sync;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic sclk, mosi, cs_n, busy, frame_done, sync_out, overrun;

    always #5 clk = ~clk;

    dac_spi_serializer_if #(.BIT_WIDTH(16)) smp ();

    dac_spi_serializer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .SIGNED_IN(1)) u_dut (
        .clk_sys(clk), .rst(rst), .en(en), .smp(smp),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
        .frame_done(frame_done), .sync_out(sync_out), .overrun(overrun)
    );

    // Second instance: unsigned pass-through variant.
    logic u_rst = 1'b1;
    logic u_en  = 1'b0;
    logic u_sclk, u_mosi, u_cs_n, u_busy, u_fd, u_sync, u_ovr;
    bit   u_done = 0;

    dac_spi_serializer_if #(.BIT_WIDTH(16)) smp_u ();

    dac_spi_serializer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .SIGNED_IN(0)) u_dut_u (
        .clk_sys(clk), .rst(u_rst), .en(u_en), .smp(smp_u),
        .sclk(u_sclk), .mosi(u_mosi), .cs_n(u_cs_n), .busy(u_busy),
        .frame_done(u_fd), .sync_out(u_sync), .overrun(u_ovr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // ---------------- reference model (timeline) ----------------
    exp_t exp_q[$];
    int   cyc   = 0;
    bit   f_act = 0;     // a frame was accepted and not aborted
    int   acc   = 0;     // cycle of its acceptance
    bit   ovr_m = 0;
    bit   en_p  = 0;
    bit   rst_p = 1;

    function automatic bit in_rng(input int lo, input int hi);
        return f_act && cyc >= acc + lo && cyc <= acc + hi;
    endfunction

    function automatic bit ready_m();
        return en_p && !rst_p && !in_rng(1, BUSY_N);
    endfunction

    function automatic logic [23:0] signed_word(input logic [15:0] d);
        logic [15:0] ob;
        ob = d + 16'h8000;                              // offset binary, mod 2^16
        return (24'h30 << 16) + 24'(ob);
    endfunction

    // One clock cycle: check outputs for this cycle, drive inputs, update model.
    task automatic step(input bit r, input bit e, input bit v, input logic [15:0] d, input bit le);
        bit   rdy;
        exp_t x;
        @(negedge clk);
        rdy = ready_m();
        chk("data_ready", smp.data_ready, rdy);
        chk("busy", busy, in_rng(1, BUSY_N));
        chk("cs_n", cs_n, !in_rng(1, SHIFT_N));
        chk("frame_done", frame_done, in_rng(SHIFT_N + 1, SHIFT_N + 1));
        chk("overrun", overrun, ovr_m);
        if (!in_rng(1, SHIFT_N)) begin
            chk("sclk_idle", sclk, 0);
            chk("mosi_idle", mosi, 0);
        end
        if (!in_rng(SHIFT_N + 1, SHIFT_N + 1)) chk("sync_idle", sync_out, 0);
        rst = r; en = e;
        smp.data_valid = v; smp.data_in = d; smp.lut_end_in = le;
        @(posedge clk);
        if (r || !e) begin
            if (in_rng(1, SHIFT_N)) exp_q[$].abort = 1;
            f_act = 0;
            if (r) ovr_m = 0;
        end else if (v && rdy) begin
            x.word = signed_word(d); x.sync = le; x.abort = 0;
            exp_q.push_back(x);
            f_act = 1;
            acc   = cyc;
        end else if (v) begin
            ovr_m = 1;
        end
        en_p = e; rst_p = r; cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 16'h0, 0);
    endtask

    task automatic send(input logic [15:0] d, input bit le);
        for (int i = 0; i < 300 && !ready_m(); i++) idle(1);
        if (!ready_m()) fail_now("send_ready_timeout");
        step(0, 1, 1, d, le);
    endtask

    // ---------------- SPI monitor (main instance) ----------------
    logic        m_prev_cs = 1'b1, m_prev_sclk = 1'b0, m_held = 1'b0;
    logic [23:0] m_bits = '0;
    int          m_nb = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!m_prev_cs && m_prev_sclk && !sclk) begin
            m_bits = {m_bits[22:0], m_held};
            m_nb++;
        end
        if (m_prev_sclk && sclk && !cs_n) chk("mosi_stable", mosi, m_held);
        if (sclk) m_held = mosi;
        if (m_prev_cs && !cs_n) begin
            m_bits = '0;
            m_nb   = 0;
        end
        if (!m_prev_cs && cs_n) begin
            if (exp_q.size() == 0) fail_now("frame_end_unexpected");
            else begin
                e = exp_q.pop_front();
                chk("frame_complete", frame_done, !e.abort);
                if (frame_done) begin
                    chk("bit_count", m_nb, 24);
                    chk("frame_word", m_bits, e.word);
                    chk("sync_out", sync_out, e.sync);
                end
            end
        end
        m_prev_cs   = cs_n;
        m_prev_sclk = sclk;
    end

    // ---------------- unsigned instance ----------------
    exp_t        u_q[$];
    logic        u_prev_cs = 1'b1, u_prev_sclk = 1'b0, u_held = 1'b0;
    logic [23:0] u_bits = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!u_prev_cs && u_prev_sclk && !u_sclk) u_bits = {u_bits[22:0], u_held};
        if (u_sclk) u_held = u_mosi;
        if (u_fd) begin
            if (u_q.size() == 0) fail_now("unsigned_frame_unexpected");
            else begin
                e = u_q.pop_front();
                chk("unsigned_word", u_bits, e.word);
                chk("unsigned_sync", u_sync, e.sync);
            end
        end
        u_prev_cs   = u_cs_n;
        u_prev_sclk = u_sclk;
    end

    initial begin
        logic [15:0] ud [2];
        exp_t        x;
        int          w;
        ud[0] = 16'h8000;
        ud[1] = 16'($urandom);
        smp_u.data_valid = 0; smp_u.data_in = '0; smp_u.lut_end_in = 0;
        repeat (2) @(negedge clk);
        u_rst = 0; u_en = 1;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            @(negedge clk);
            while (!smp_u.data_ready && w < 300) begin @(negedge clk); w++; end
            if (!smp_u.data_ready) fail_now("unsigned_ready_timeout");
            smp_u.data_valid = 1; smp_u.data_in = ud[k]; smp_u.lut_end_in = (k == 0);
            x.word = (24'h30 << 16) + 24'(ud[k]); x.sync = (k == 0); x.abort = 0;
            u_q.push_back(x);
            @(negedge clk);
            smp_u.data_valid = 0;
        end
        w = 0;
        while (u_q.size() != 0 && w < 400) begin @(negedge clk); w++; end
        if (u_q.size() != 0) fail_now("unsigned_drain_timeout");
        repeat (4) @(negedge clk);
        chk("unsigned_busy_end", u_busy, 0);
        chk("unsigned_overrun", u_ovr, 0);
        u_done = 1;
    end

    // ---------------- main stimulus ----------------
    initial begin
        int w;
        smp.data_valid = 0; smp.data_in = '0; smp.lut_end_in = 0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 0);       // reset state
        step(0, 0, 1, 16'hAAAA, 0);                                // en low: valid ignored
        step(0, 1, 1, 16'h5555, 0);                                // en rising + valid: not taken
        step(1, 1, 0, 16'h0, 0);                                   // clear the overrun that set
        idle(1);

        send(16'h1234, 0);                                         // 0x309234
        send(16'h8000, 0);                                         // payload 0x0000
        send(16'h4321, 1);                                         // sync on this frame only
        send(16'h0FED, 0);

        for (int i = 0; i < 300; i++)                              // valid every cycle
            step(0, 1, 1, 16'($urandom), 1'($urandom));
        step(1, 1, 0, 16'h0, 0);                                   // rst mid-stream clears overrun
        idle(2);

        send(16'hBEEF, 1);                                         // abort at SHIFT cycle 30
        idle(29);
        step(0, 0, 0, 16'h0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            bit r, e, v;
            r = ($urandom_range(0, 1499) == 0);
            e = ($urandom_range(0, 399) != 0);
            v = ($urandom_range(0, 39) == 0);
            step(r, e, v, 16'($urandom), 1'($urandom));
        end
        idle(250);
        chk("queue_drained", exp_q.size(), 0);

        w = 0;
        while (!u_done && w < 1000) begin @(negedge clk); w++; end
        if (!u_done) fail_now("unsigned_done_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
